// File: rtl/module_add_zero_point_1x8.sv
// module_add_zero_point_1x8
//   Adds a signed 8-bit output zero point to eight signed 16-bit requantized
//   lanes and clamps each lane to an unsigned 8-bit activation.
//   Two-stage valid/ready pipeline:
//     S1 holds the 17-bit sums.
//     S2 holds the clamped bytes.
//   Sustains one beat per cycle with a latency of 2 cycles.
//
// Optional feature (macro ADD_ZP_SAT_CNT_EN):
//   Adds a saturating counter of clamped lanes, counted on each output
//   transfer, with a synchronous clear.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   zero_point        signed 8-bit zero point, captured with each accepted beat
//   in_valid/in_ready input handshake
//   data_in           8 x signed 16-bit lanes, lane i at [16i+15:16i]
//   out_valid/out_ready output handshake
//   data_out          8 x unsigned 8-bit lanes, lane i at [8i+7:8i]
//   sat_clr, sat_cnt  counter clear / clamped-lane count (ADD_ZP_SAT_CNT_EN only)
module module_add_zero_point_1x8 #(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [7:0]    zero_point,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          data_out
`ifdef ADD_ZP_SAT_CNT_EN
  ,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_cnt
`endif
);

  logic        stall;
  logic        s1_valid;
  logic [16:0] s1_sum [8];
  logic [16:0] sum_d  [8];
  logic [63:0] clamp_d;

  // A full output stage that is not being taken freezes the whole pipe.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // 17-bit two's-complement sum; both operands are sign-extended by hand.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      sum_d[i] = {data_in[16*i+15], data_in[16*i +: 16]}
               + {{9{zero_point[7]}}, zero_point};
    end
  end

  // Negative sums have bit 16 set.
  // A non-negative sum above 255 has a set bit somewhere in [15:8].
  always_comb begin
    clamp_d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (s1_sum[i][16]) begin
        clamp_d[8*i +: 8] = '0;
      end else if (|s1_sum[i][15:8]) begin
        clamp_d[8*i +: 8] = '1;
      end else begin
        clamp_d[8*i +: 8] = s1_sum[i][7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        s1_sum[i] <= '0;
      end
    end else if (!stall) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      data_out  <= clamp_d;
      for (int unsigned i = 0; i < 8; i++) begin
        s1_sum[i] <= sum_d[i];
      end
    end
  end

`ifdef ADD_ZP_SAT_CNT_EN
  logic [3:0]           nsat_d;
  logic [3:0]           s2_nsat;
  logic [SAT_CNT_W:0]   cnt_sum;

  // Count of clamped lanes is computed alongside the clamp.
  // It travels with the beat through S2 so it is added exactly when that
  // beat is handed downstream.
  always_comb begin
    nsat_d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      nsat_d = nsat_d + 4'(s1_sum[i][16] | (|s1_sum[i][15:8]));
    end
  end

  assign cnt_sum = {1'b0, sat_cnt} + (SAT_CNT_W+1)'(s2_nsat);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_nsat <= '0;
      sat_cnt <= '0;
    end else begin
      if (!stall) begin
        s2_nsat <= nsat_d;
      end
      if (sat_clr) begin
        sat_cnt <= '0;
      end else if (out_valid && out_ready) begin
        sat_cnt <= cnt_sum[SAT_CNT_W] ? '1 : cnt_sum[SAT_CNT_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_module_add_zero_point_1x8.sv
// tb_module_add_zero_point_1x8
//   Scoreboard bench for module_add_zero_point_1x8.
//
// Stimulus and checking:
//   The driver pushes the expected output of each accepted beat.
//   A monitor pops and compares on every output transfer, and checks that
//   data_out holds the head beat while stalled.
//
// Timing:
//   Inputs change #1 after posedge.
//   Outputs are sampled on negedge.
module tb_module_add_zero_point_1x8;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   zero_point;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  data_out;
`ifdef ADD_ZP_SAT_CNT_EN
  logic         sat_clr;
  logic [3:0]   sat_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int last_out_cyc = 0;
  int consec_seen  = 0;
  bit consec_mode  = 1'b0;

  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  module_add_zero_point_1x8 #(.SAT_CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .zero_point (zero_point),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out)
`ifdef ADD_ZP_SAT_CNT_EN
    ,
    .sat_clr    (sat_clr),
    .sat_cnt    (sat_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference clamp using integer arithmetic.
  function automatic logic [63:0] model(input logic [127:0] d, input logic [7:0] zp);
    logic [63:0] r;
    logic [15:0] l;
    int s;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      l = d[16*k +: 16];
      s = int'($signed(l)) + int'($signed(zp));
      if (s < 0)        r[8*k +: 8] = 8'd0;
      else if (s > 255) r[8*k +: 8] = 8'd255;
      else              r[8*k +: 8] = 8'(s);
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor process.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", data_out, 64'hx);
        end else begin
          check("beat_data", data_out, exp_q.pop_front());
        end
        if (consec_mode) begin
          if (consec_seen > 0) check("b2b_consecutive", 64'(cyc), 64'(last_out_cyc + 1));
          last_out_cyc = cyc;
          consec_seen++;
        end
      end else if (exp_q.size() != 0) begin
        check("stall_hold", data_out, exp_q[0]);
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [7:0] zp, input logic [63:0] exp);
    bit done;
    done       = 1'b0;
    data_in    = d;
    zero_point = zp;
    in_valid   = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  logic [127:0] d;
  logic [7:0]   zp;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    data_in    = '0;
    zero_point = '0;
    out_ready  = 1'b1;
`ifdef ADD_ZP_SAT_CNT_EN
    sat_clr    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_data_out",  data_out,       64'd0);
`ifdef ADD_ZP_SAT_CNT_EN
    check("rst_sat_cnt",   64'(sat_cnt),   64'd0);
`endif
    @(posedge clk);
    #1;

    // Basic beat: zp=5, lanes 10 -> 15, out_valid after the second edge.
    send({8{16'd10}}, 8'd5, 64'h0F0F_0F0F_0F0F_0F0F);
    @(negedge clk);
    check("lat_cycle1_invalid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    wait_drain();

    // Clamp vector with zp=-128.
    send({16'h7FFF, 16'h8000, 16'd384, 16'd383, 16'd128, 16'd127, 16'd0, 16'hFFFF},
         8'h80, 64'hFF00_FFFF_0000_0000);
    wait_drain();

    // 16 back-to-back beats.
    consec_mode = 1'b1;
    consec_seen = 0;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 8; k++) d[16*k +: 16] = 16'(b * 37 + k * 29 - 100);
      zp = 8'(b * 3 - 20);
      send(d, zp, model(d, zp));
    end
    wait_drain();
    consec_mode = 1'b0;
    check("b2b_count", 64'(consec_seen), 64'd16);

    // Backpressure: out_ready low for 5 cycles while input keeps coming.
    out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          for (int k = 0; k < 8; k++) d[16*k +: 16] = 16'(b * 50 + k * 7 - 60);
          zp = 8'(b * 40 - 100);
          send(d, zp, model(d, zp));
        end
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
          @(negedge clk);
          seen = out_valid;
        end
        if (!seen) check("bp_valid_timeout", 64'd0, 64'd1);
        for (int n = 0; n < 5; n++) begin
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-stream with two beats in flight.
    out_ready = 1'b0;
    send({8{16'd1}}, 8'd1, 64'h0202_0202_0202_0202);
    send({8{16'd2}}, 8'd2, 64'h0404_0404_0404_0404);
    pulse_reset();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_data_out",  data_out,       64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send({8{16'd20}}, 8'hF6, 64'h0A0A_0A0A_0A0A_0A0A);
    wait_drain();

`ifdef ADD_ZP_SAT_CNT_EN
    // Counter: two fully clamped beats saturate a 4-bit count at 15.
    pulse_reset();
    send({8{16'h7FFF}}, 8'd0, {8{8'hFF}});
    send({8{16'h8000}}, 8'd0, 64'd0);
    wait_drain();
    @(negedge clk);
    check("sat_cnt_saturate", 64'(sat_cnt), 64'd15);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send({8{16'h7FFF}}, 8'd0, {8{8'hFF}});
    @(posedge clk);
    #1;
    check("satclr_out_valid", 64'(out_valid), 64'd1);
    sat_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check("sat_cnt_clear", 64'(sat_cnt), 64'd0);
    wait_drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/module_add_zero_point_1x8.md
MODULE_ADD_ZERO_POINT_1X8 -- requirements
Module: module_add_zero_point_1x8

Interface
REQ-001 SHALL have parameter SAT_CNT_W, default 16, the width of the saturation event counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port zero_point, input, 8 bits, signed: the output zero point, sampled together with each accepted beat.
REQ-005 SHALL have port in_valid, input, 1 bit: an input beat is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 SHALL have port data_in, input, 128 bits: 8 signed 16-bit requantized lanes, lane i at bits [16i+15:16i].
REQ-008 SHALL have port out_valid, output, 1 bit: an output beat is present.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream accepts the output beat.
REQ-010 SHALL have port data_out, output, 64 bits: 8 unsigned 8-bit activations, lane i at bits [8i+7:8i].
REQ-011 SHALL have port sat_clr, input, 1 bit: clears the saturation counter (present only with ADD_ZP_SAT_CNT_EN).
REQ-012 SHALL have port sat_cnt, output, SAT_CNT_W bits: saturated-lane count (present only with ADD_ZP_SAT_CNT_EN).

Function
REQ-013 SHALL transfer a beat on any edge where valid and ready are both high, on either side.
REQ-014 SHALL implement a 2-stage pipeline, each stage consisting of a valid bit plus data.
- S1 holds the per-lane 17-bit signed sum data_in[i] + sign-extended zero_point.
- S2 holds the per-lane clamped 8-bit result.
REQ-015 SHALL define stall = out_valid AND NOT out_ready, and SHALL drive in_ready = NOT stall combinationally.
REQ-016 SHALL, when stall is low, advance the pipeline: S1 <= input beat (valid = in_valid), S2 <= S1.
REQ-017 SHALL, when stall is high, hold S1 and S2 unchanged and accept no input.
REQ-018 SHALL have a latency of 2 cycles from input transfer to out_valid when unstalled, and SHALL sustain 1 beat per cycle.
REQ-019 SHALL clamp each lane as: sum < 0 -> 0; sum > 255 -> 255; otherwise sum[7:0].
REQ-020 SHALL treat lanes independently: saturation of one lane does not affect the other lanes.
REQ-021 SHALL keep data_out stable while out_valid is high and out_ready is low.
REQ-022 SHALL NOT create or drop beats: output order equals input order, and the beat count is conserved.
REQ-023 SHALL NOT allow zero_point changes to alter beats already accepted.

Reset
REQ-024 SHALL, while rst is high, clear both stage valid bits, so out_valid = 0 and in_ready = 1 on the next cycle.
REQ-025 SHALL reset data_out to 0 and sat_cnt to 0.
REQ-026 SHALL, on rst asserted mid-stream, discard all in-flight beats with no output transfer from them.

Configuration
REQ-027 SHALL, with macro ADD_ZP_SAT_CNT_EN defined, provide sat_clr and sat_cnt.
- On each output transfer, sat_cnt increments by the number of lanes (0-8) clamped in that beat.
- sat_cnt saturates at all-ones.
- sat_clr sets sat_cnt to 0 and takes priority over a simultaneous increment.
REQ-028 SHALL, without ADD_ZP_SAT_CNT_EN, omit sat_clr, sat_cnt and the counting logic, leaving datapath behaviour unchanged.

Verification
REQ-029 SHALL cover a basic beat: zero_point=5, all lanes 10, out_ready=1 -> out_valid 2 cycles later, all lanes 15.
REQ-030 SHALL cover clamping: zero_point=-128, lanes {-1,0,127,128,383,384,-32768,32767} -> {0,0,0,0,255,255,0,255}.
REQ-031 SHALL cover back-to-back traffic: 16 back-to-back beats with out_ready=1 -> 16 outputs on consecutive cycles, in order.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 once out_valid is high, data_out held; after release, all beats delivered with no loss or duplication.
REQ-033 SHALL cover reset mid-stream: rst pulsed for 1 cycle with 2 beats in flight -> out_valid=0 next cycle and no stale beat emitted afterwards.
REQ-034 SHALL cover the counter (ADD_ZP_SAT_CNT_EN, SAT_CNT_W=4): 2 beats with 8 clamped lanes each -> sat_cnt=15; sat_clr together with a transfer -> sat_cnt=0.
